// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and optional hold timeout.
// grant_id steers the shared datapath mux; it is meaningful only while busy is high.
module rr_arbiter_4 #(
    parameter int unsigned         CNT_W    = 8,
    parameter logic [CNT_W-1:0]    MAX_HOLD = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t           state, state_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] hold_cnt, cnt_nx;
    logic [3:0]       grant_nx;
    logic [1:0]       id_nx;
    logic             timeout_nx;

    // Returns {found, index}: first requester at or after p, wrapping mod 4.
    function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic       req_own;
    logic       hold_to;
    logic       rotate;
    logic [1:0] rot_ptr;
    logic [2:0] pick_idle;
    logic [2:0] pick_rot;

    assign req_own   = req[grant_id];
    assign hold_to   = (MAX_HOLD != '0) && (hold_cnt == MAX_HOLD);
    assign rotate    = !req_own || hold_to;
    assign rot_ptr   = grant_id + 2'd1;
    assign pick_idle = pick(ptr, req);
    assign pick_rot  = pick(rot_ptr, req);

    // State register: FSM state, pointer, hold counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= cnt_nx;
            grant    <= grant_nx;
            grant_id <= id_nx;
            busy     <= |grant_nx;
            timeout  <= timeout_nx;
        end
    end

    // Next-state: ownership, priority pointer and hold counter.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nx = OWN;
                    cnt_nx   = CNT_W'(1);
                end
            end
            OWN: begin
                if (rotate) begin
                    ptr_nx = rot_ptr;
                    if (pick_rot[2]) begin
                        cnt_nx = CNT_W'(1);
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (hold_cnt != '1) begin
                    cnt_nx = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: next grant vector, owner index and timeout pulse.
    always_comb begin
        grant_nx   = 4'b0000;
        id_nx      = 2'd0;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    grant_nx = 4'b0001 << pick_idle[1:0];
                    id_nx    = pick_idle[1:0];
                end
            end
            OWN: begin
                if (rotate) begin
                    timeout_nx = req_own && hold_to;
                    if (pick_rot[2]) begin
                        grant_nx = 4'b0001 << pick_rot[1:0];
                        id_nx    = pick_rot[1:0];
                    end
                end else begin
                    grant_nx = grant;
                    id_nx    = grant_id;
                end
            end
            default: begin
                grant_nx = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: two instances (no timeout, MAX_HOLD=4) checked each cycle
// against a behavioural arbiter model, plus directed literal expectations.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] g   [2];
    logic [1:0] gid [2];
    logic       bz  [2];
    logic       to  [2];

    int errors = 0;
    int checks = 0;

    rr_arbiter_4 #(.CNT_W(8), .MAX_HOLD(8'd0)) dut0 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g[0]), .grant_id(gid[0]), .busy(bz[0]), .timeout(to[0])
    );

    rr_arbiter_4 #(.CNT_W(8), .MAX_HOLD(8'd4)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g[1]), .grant_id(gid[1]), .busy(bz[1]), .timeout(to[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: own = -1 when nobody holds the grant.
    typedef struct packed {
        int own;
        int ptr;
        int cnt;
        bit to;
    } model_t;

    model_t m [2];

    function automatic int first_req(input int p, input logic [3:0] q);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (p + i) % 4;
            if (q[j]) return j;
        end
        return -1;
    endfunction

    function automatic model_t step(input model_t s, input int mh, input logic r, input logic [3:0] q);
        model_t n;
        n = s;
        n.to = 1'b0;
        if (r) begin
            n.own = -1; n.ptr = 0; n.cnt = 0;
        end else if (s.own < 0) begin
            n.own = first_req(s.ptr, q);
            n.cnt = (n.own >= 0) ? 1 : 0;
        end else if (!q[s.own]) begin
            n.ptr = (s.own + 1) % 4;
            n.own = first_req(n.ptr, q);
            n.cnt = (n.own >= 0) ? 1 : 0;
        end else if (mh != 0 && s.cnt == mh) begin
            n.ptr = (s.own + 1) % 4;
            n.own = first_req(n.ptr, q);
            n.cnt = 1;
            n.to  = 1'b1;
        end else begin
            n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
        end
        return n;
    endfunction

    initial begin
        m[0] = '0;
        m[1] = '0;
        m[0].own = -1;
        m[1].own = -1;
    end

    always @(posedge clk) begin
        m[0] <= step(m[0], 0, rst, req);
        m[1] <= step(m[1], 4, rst, req);
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eg;
            eg = (m[k].own < 0) ? 4'b0000 : 4'(1 << m[k].own);
            chk("grant", k, 32'(g[k]), 32'(eg));
            chk("busy", k, 32'(bz[k]), 32'(eg != 4'b0000));
            chk("timeout", k, 32'(to[k]), 32'(m[k].to));
            if (m[k].own >= 0) chk("grant_id", k, 32'(gid[k]), 32'(m[k].own));
        end
    end

    task automatic cyc(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);

        // Reset holds everything low even with all requests present.
        cyc(1'b1, 4'b1111);
        chk("t1_grant_rst", 0, 32'(g[0]), 32'h0);
        chk("t1_busy_rst", 0, 32'(bz[0]), 32'h0);
        chk("t1_to_rst", 1, 32'(to[1]), 32'h0);
        cyc(1'b0, 4'b1111);
        chk("t1_first_grant", 0, 32'(g[0]), 32'h1);

        // Single requester.
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0100);
        chk("t2_grant", 0, 32'(g[0]), 32'h4);
        chk("t2_id", 0, 32'(gid[0]), 32'h2);
        cyc(1'b0, 4'b0000);
        chk("t2_release", 0, 32'(g[0]), 32'h0);
        chk("t2_busy", 0, 32'(bz[0]), 32'h0);

        // Fairness: each owner drops its request after three granted cycles.
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b1111);
        for (int o = 0; o < 4; o++) begin
            chk("t3_order", 0, 32'(g[0]), 32'(1 << o));
            cyc(1'b0, 4'b1111);
            cyc(1'b0, 4'b1111);
            cyc(1'b0, 4'b1111 & ~4'(1 << o));
        end
        chk("t3_wrap", 0, 32'(g[0]), 32'h1);

        // Direct handoff from owner 1 to owner 3.
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0010);
        chk("t4_owner1", 0, 32'(g[0]), 32'h2);
        cyc(1'b0, 4'b1011);
        cyc(1'b0, 4'b1001);
        chk("t4_handoff", 0, 32'(g[0]), 32'h8);
        chk("t4_no_bubble", 0, 32'(bz[0]), 32'h1);

        // Timeout rotation on the MAX_HOLD=4 instance.
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b0011);
            chk("t5_hold0", 1, 32'({to[1], g[1]}), 32'h01);
        end
        cyc(1'b0, 4'b0011);
        chk("t5_rot1", 1, 32'({to[1], g[1]}), 32'h12);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b0011);
            chk("t5_hold1", 1, 32'({to[1], g[1]}), 32'h02);
        end
        cyc(1'b0, 4'b0011);
        chk("t5_rot0", 1, 32'({to[1], g[1]}), 32'h11);

        // Solo requester keeps being re-granted with a pulse.
        cyc(1'b1, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b0001);
            chk("t5_solo_hold", 1, 32'({to[1], g[1]}), 32'h01);
        end
        cyc(1'b0, 4'b0001);
        chk("t5_solo_pulse", 1, 32'({to[1], g[1]}), 32'h11);
        cyc(1'b0, 4'b0001);
        chk("t5_solo_after", 1, 32'({to[1], g[1]}), 32'h01);

        // Mid-grant reset clears the pointer.
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0100);
        chk("t6_owner2", 0, 32'(g[0]), 32'h4);
        cyc(1'b1, 4'b1111);
        chk("t6_rst_drop", 0, 32'(g[0]), 32'h0);
        cyc(1'b0, 4'b1111);
        chk("t6_ptr0", 0, 32'(g[0]), 32'h1);

        // Randomized phase: sticky requests with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] q;
            q = req;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) q[b] = ~q[b];
            cyc(($urandom_range(99) == 0), q);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
